ctrl_decode_pipe: RTL

Registered, parametrised decode/control stage for the RV32IM core, sitting between the IF/ID register and the execute stage. It decodes opcode, func3 and func7, including full M-extension recognition, into a registered control bundle with a valid flag. It sequences multi-cycle MUL/DIV operations with a latency counter and stalls upstream while one is in flight. It also supports pipeline flush and flags illegal encodings.

---
 rtl/ctrl_decode_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: RV32IM decode stage producing a registered control bundle, sequencing multi-cycle MUL/DIV with stall and flush; ports: clk, rst, id_valid/id_instr/flush in, stall_o, ex_valid, control flags, md_start/md_op/md_busy, illegal out
module ctrl_decode_pipe #(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        flush,
  output logic        stall_o,
  output logic        ex_valid,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        lui,
  output logic        auipc,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_busy,
  output logic        illegal
);
  localparam int LAT_MAX = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(LAT_MAX) > 0 ? $clog2(LAT_MAX) : 1;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  typedef enum logic {RUN, MD_WAIT} state_t;
  typedef struct packed {
    logic       reg_write, alu_src, mem_read, mem_write, branch, jal, jalr, lui, auipc;
    logic [1:0] mem_to_reg, mem_size;
    logic       mem_unsigned, illegal;
  } ctrl_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d, dec;
  logic          ex_valid_q, ex_valid_d, md_start_q, md_start_d;
  logic [2:0]    md_op_q, md_op_d;
  logic          bad, is_m, unused_bits;
  logic [6:0]    opcode, f7;
  logic [2:0]    f3;
  assign opcode = id_instr[6:0];
  assign f3 = id_instr[14:12];
  assign f7 = id_instr[31:25];
  assign unused_bits = ^{id_instr[24:15], id_instr[11:7]};
  assign is_m = opcode == OP_R && f7 == 7'b0000001;
  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OP_R:     begin dec.reg_write = 1'b1; bad = is_m && !ENABLE_M; end
      OP_I:     begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      OP_LD:    begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 2'b01;
        dec.mem_size = f3[1:0]; dec.mem_unsigned = f3[2];
        bad = f3 == 3'd3 || f3 >= 3'd6;
      end
      OP_ST:    begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.mem_size = f3[1:0]; bad = f3 > 3'd2; end
      OP_BR:    dec.branch = 1'b1;
      OP_JAL:   begin dec.reg_write = 1'b1; dec.jal = 1'b1; dec.mem_to_reg = 2'b10; end
      OP_JALR:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.jalr = 1'b1; dec.mem_to_reg = 2'b10; end
      OP_LUI:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.lui = 1'b1; end
      OP_AUIPC: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.auipc = 1'b1; end
      default:  bad = 1'b1;
    endcase
    if (bad) begin
      dec.illegal = 1'b1;
      {dec.reg_write, dec.mem_read, dec.mem_write, dec.branch, dec.jal, dec.jalr} = '0;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ctrl_d = '0;
    ex_valid_d = 1'b0;
    md_start_d = 1'b0;
    md_op_d = md_op_q;
    if (state_q == RUN) begin
      if (id_valid && !flush) begin
        if (ENABLE_M && is_m) begin
          state_d = MD_WAIT;
          md_start_d = 1'b1;
          md_op_d = f3;
          cnt_d = f3[2] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
        end else begin
          ex_valid_d = 1'b1;
          ctrl_d = dec;
        end
      end
    end else if (flush) begin
      state_d = RUN;
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      state_d = RUN;
      ex_valid_d = 1'b1;
      ctrl_d.reg_write = 1'b1;
      ctrl_d.mem_to_reg = 2'b11;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      ctrl_q <= '0;
      ex_valid_q <= 1'b0;
      md_start_q <= 1'b0;
      md_op_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
      ex_valid_q <= ex_valid_d;
      md_start_q <= md_start_d;
      md_op_q <= md_op_d;
    end
  end
  assign stall_o = state_q == MD_WAIT;
  assign md_busy = state_q == MD_WAIT;
  assign ex_valid = ex_valid_q;
  assign md_start = md_start_q;
  assign md_op = md_op_q;
  assign {reg_write, alu_src, mem_read, mem_write, branch, jal, jalr, lui, auipc} =
         {ctrl_q.reg_write, ctrl_q.alu_src, ctrl_q.mem_read, ctrl_q.mem_write, ctrl_q.branch,
          ctrl_q.jal, ctrl_q.jalr, ctrl_q.lui, ctrl_q.auipc};
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_size = ctrl_q.mem_size;
  assign mem_unsigned = ctrl_q.mem_unsigned;
  assign illegal = ctrl_q.illegal;
endmodule
